// File: rtl/wb_stream_fetch.sv
// Memory-to-stream fetch engine: Wishbone burst-read master walking a circular
// buffer, feeding a first-word-fall-through FIFO that drives a valid/ready stream.
module wb_stream_fetch #(
  parameter int WB_DW         = 32,
  parameter int WB_AW         = 32,
  parameter int FIFO_AW       = 4,
  parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic               wbm_rty_i,
  output logic [WB_DW-1:0]   stream_m_data_o,
  output logic               stream_m_valid_o,
  input  logic               stream_m_ready_i,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy_o,
  output logic               wrap_o,
  output logic               err_o
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int BYTES = WB_DW/8;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_ERROR} state_t;

  state_t             state_q;
  logic [WB_AW-1:0]   base_q, buf_q, bsz_q, idx_q, beat_q, len_q, adr_q;
  logic               cyc_q, wrap_q;
  logic [2:0]         cti_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic [WB_DW-1:0]   mem_q [DEPTH];

  logic [WB_AW-1:0]   rem_d, len_d, free_d, idx_sum_d;
  logic               ack_d, push_d, pop_d, last_d;

  function automatic logic [WB_AW-1:0] clip_len(input logic [WB_AW-1:0] n);
    if (n == '0) return WB_AW'(1);
    if (n > WB_AW'(MAX_BURST_LEN)) return WB_AW'(MAX_BURST_LEN);
    return n;
  endfunction

  // Free space uses the registered count only, so a pop in the deciding cycle is not credited.
  assign rem_d     = buf_q - idx_q;
  assign len_d     = (bsz_q < rem_d) ? bsz_q : rem_d;
  assign free_d    = WB_AW'(DEPTH) - WB_AW'(cnt_q);
  assign idx_sum_d = idx_q + len_q;
  assign ack_d     = wbm_ack_i & ~wbm_rty_i;
  assign push_d    = cyc_q & ack_d & ~wbm_err_i;
  assign pop_d     = (cnt_q != '0) & stream_m_ready_i;
  assign last_d    = (beat_q == len_q - WB_AW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      adr_q   <= '0;
      base_q  <= '0;
      buf_q   <= '0;
      bsz_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (enable && buf_size != '0) begin
            base_q  <= start_adr;
            buf_q   <= buf_size;
            bsz_q   <= clip_len(burst_size);
            idx_q   <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (free_d >= len_d) begin
            state_q <= S_BURST;
            cyc_q   <= 1'b1;
            len_q   <= len_d;
            beat_q  <= '0;
            adr_q   <= base_q + idx_q * WB_AW'(BYTES);
            cti_q   <= (len_d == WB_AW'(1)) ? CTI_END : CTI_INC;
          end
        end
        S_BURST: begin
          if (wbm_err_i) begin
            state_q <= S_ERROR;
            cyc_q   <= 1'b0;
            cti_q   <= CTI_CLASSIC;
          end else if (ack_d) begin
            if (last_d) begin
              cyc_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              state_q <= enable ? S_WAIT : S_IDLE;
              if (idx_sum_d == buf_q) begin
                idx_q  <= '0;
                wrap_q <= 1'b1;
              end else begin
                idx_q  <= idx_sum_d;
              end
            end else begin
              beat_q <= beat_q + WB_AW'(1);
              adr_q  <= adr_q + WB_AW'(BYTES);
              cti_q  <= (beat_q + WB_AW'(2) == len_q) ? CTI_END : CTI_INC;
            end
          end
        end
        S_ERROR: begin
          if (!enable) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_d)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_d, pop_d})
        2'b10:   cnt_q <= cnt_q + (FIFO_AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (FIFO_AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_d) mem_q[wr_ptr_q] <= wbm_dat_i;
  end

  assign wbm_adr_o        = adr_q;
  assign wbm_dat_o        = '0;
  assign wbm_sel_o        = '1;
  assign wbm_we_o         = 1'b0;
  assign wbm_cyc_o        = cyc_q;
  assign wbm_stb_o        = cyc_q;
  assign wbm_cti_o        = cti_q;
  assign wbm_bte_o        = 2'b00;
  assign stream_m_data_o  = mem_q[rd_ptr_q];
  assign stream_m_valid_o = (cnt_q != '0);
  assign busy_o           = (state_q != S_IDLE);
  assign wrap_o           = wrap_q;
  assign err_o            = (state_q == S_ERROR);

endmodule

// File: tb/tb_wb_stream_fetch.sv
// Bench for wb_stream_fetch: random Wishbone slave and stream sink, with a
// buffer-position/queue reference model checked every cycle plus directed pins.
module tb_wb_stream_fetch;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o, stream_m_ready_i = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0;
  logic        busy_o, wrap_o, err_o;

  always #5 clk = ~clk;

  wb_stream_fetch #(.WB_DW(32), .WB_AW(32), .FIFO_AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i), .enable(enable), .start_adr(start_adr),
    .buf_size(buf_size), .burst_size(burst_size), .busy_o(busy_o),
    .wrap_o(wrap_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Slave: data equals address; random ack/retry; optional error on a chosen beat.
  int ack_pct = 100, rty_pct = 0, inj_err_beat = 0, slave_beat = 0;
  bit drove_cyc = 0;
  bit rand_ready = 0;

  always @(posedge clk) begin
    #1;
    if (drove_cyc && wbm_ack_i && !wbm_err_i && !wbm_rty_i) slave_beat++;
    if (!wbm_cyc_o) slave_beat = 0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = wbm_adr_o;
    if (wbm_cyc_o) begin
      if (inj_err_beat != 0 && slave_beat == inj_err_beat - 1) begin
        wbm_err_i = 1'b1;
        wbm_ack_i = 1'($urandom_range(0, 1));
        inj_err_beat = 0;
      end else if ($urandom_range(0, 99) < ack_pct) begin
        wbm_ack_i = 1'b1;
      end else if ($urandom_range(0, 99) < rty_pct) begin
        wbm_rty_i = 1'b1;
      end
    end
    drove_cyc = wbm_cyc_o;
    if (rand_ready) stream_m_ready_i = 1'($urandom_range(0, 1));
  end

  // Reference model: buffer position, burst position, and the expected stream queue.
  typedef enum {M_IDLE, M_ACT, M_ERR} mmode_t;
  mmode_t      mmode = M_IDLE;
  logic [31:0] q[$];
  logic [31:0] m_start, m_buf, m_bs, m_p, m_b, m_L;
  bit          model_on = 0, in_burst = 0, wrap_exp = 0, cyc_low_exp = 0, cyc_high_exp = 0;
  bit          cyc_seen = 0;
  int          size_prev = 0;
  int          acks_total = 0, pops_total = 0, wraps_seen = 0;
  logic [31:0] ack_adr_log[$], pop_log[$];
  logic [2:0]  ack_cti_log[$];

  function automatic logic [31:0] burst_len(input logic [31:0] bs, input logic [31:0] bsz,
                                            input logic [31:0] p);
    logic [31:0] c;
    c = (bs == 0) ? 32'd1 : ((bs > DEPTH) ? 32'(DEPTH) : bs);
    return (c < bsz - p) ? c : bsz - p;
  endfunction

  always @(negedge clk) begin
    logic [31:0] exp_adr;
    exp_adr = '0;
    if (model_on) begin
      chk("valid", stream_m_valid_o, q.size() != 0);
      if (q.size() != 0 && stream_m_valid_o) chk("data", stream_m_data_o, q[0]);
      chk("wrap", wrap_o, wrap_exp);
      chk("busy", busy_o, mmode != M_IDLE);
      chk("err", err_o, mmode == M_ERR);
      chk("stb", wbm_stb_o, wbm_cyc_o);
      if (cyc_low_exp || mmode != M_ACT) chk("cyc_low", wbm_cyc_o, 0);
      if (cyc_high_exp) chk("cyc_start", wbm_cyc_o, 1);
      if (in_burst && mmode == M_ACT) chk("cyc_hold", wbm_cyc_o, 1);
      if (!wbm_cyc_o) chk("cti_idle", wbm_cti_o, 0);
      if (wrap_o) wraps_seen++;
      if (wbm_cyc_o) cyc_seen = 1;
      if (wbm_cyc_o && mmode == M_ACT) begin
        if (!in_burst) begin
          in_burst = 1;
          m_b = 0;
          m_L = burst_len(m_bs, m_buf, m_p);
          chk("space", 32'(DEPTH - size_prev) >= m_L, 1);
        end
        exp_adr = m_start + (m_p + m_b) * 4;
        chk("adr", wbm_adr_o, exp_adr);
        chk("cti", wbm_cti_o, (m_b == m_L - 1) ? 32'd7 : 32'd2);
      end
      wrap_exp = 0;
      cyc_low_exp = 0;
      cyc_high_exp = 0;
      size_prev = q.size();
      if (!rst_n) begin
        q.delete();
        mmode = M_IDLE;
        in_burst = 0;
      end else begin
        if (stream_m_valid_o && stream_m_ready_i && q.size() != 0) begin
          void'(q.pop_front());
          pop_log.push_back(stream_m_data_o);
          pops_total++;
        end
        case (mmode)
          M_IDLE: if (enable && buf_size != 0) begin
            m_start = start_adr; m_buf = buf_size; m_bs = burst_size; m_p = 0;
            mmode = M_ACT;
          end
          M_ACT: begin
            if (in_burst && wbm_cyc_o) begin
              if (wbm_err_i) begin
                mmode = M_ERR; in_burst = 0; cyc_low_exp = 1;
              end else if (wbm_ack_i && !wbm_rty_i) begin
                q.push_back(exp_adr);
                acks_total++;
                ack_adr_log.push_back(wbm_adr_o);
                ack_cti_log.push_back(wbm_cti_o);
                chk("fifo_bound", q.size() <= DEPTH, 1);
                m_b++;
                if (m_b == m_L) begin
                  m_p += m_L;
                  if (m_p == m_buf) begin m_p = 0; wrap_exp = 1; end
                  in_burst = 0; cyc_low_exp = 1;
                  if (!enable) mmode = M_IDLE;
                end
              end
            end else if (!enable) begin
              mmode = M_IDLE;
            end else if (32'(DEPTH - size_prev) >= burst_len(m_bs, m_buf, m_p)) begin
              cyc_high_exp = 1;
            end
          end
          M_ERR: if (!enable) mmode = M_IDLE;
          default: mmode = M_IDLE;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ack_adr_log.delete(); ack_cti_log.delete(); pop_log.delete();
    acks_total = 0; pops_total = 0; wraps_seen = 0; cyc_seen = 0;
  endtask

  task automatic wait_acks(input int n, input string name);
    int k;
    k = 0;
    while (acks_total < n && k < 2000) begin step(); k++; end
    if (k >= 2000) chk({name, "_timeout"}, acks_total, n);
  endtask

  task automatic go_idle();
    int k;
    rand_ready = 0;
    stream_m_ready_i = 1'b1;
    enable = 1'b0;
    inj_err_beat = 0;
    k = 0;
    while ((busy_o || stream_m_valid_o) && k < 2000) begin step(); k++; end
    if (k >= 2000) chk("idle_timeout", {busy_o, stream_m_valid_o}, 0);
  endtask

  task automatic configure(input logic [31:0] sa, input logic [31:0] bs_, input logic [31:0] bu);
    start_adr = sa; buf_size = bs_; burst_size = bu;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    step();
    model_on = 1;
    step(); step();
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_valid", stream_m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_cti", wbm_cti_o, 0);
    chk("rst_wrap_err", {wrap_o, err_o}, 0);
    rst_n = 1'b1;
    step();

    // Basic fetch, wrap and restart
    clear_logs();
    configure(32'h1000, 8, 4);
    stream_m_ready_i = 1'b1;
    enable = 1'b1;
    step(); chk("lat_wait", wbm_cyc_o, 0);
    step(); chk("lat_burst", wbm_cyc_o, 1);
    chk("first_adr", wbm_adr_o, 32'h1000);
    wait_acks(8, "t1");
    chk("t1_wrap_pulse", wrap_o, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_adr", ack_adr_log[i], 32'h1000 + 32'(i * 4));
      chk("t1_cti", 32'(ack_cti_log[i]), (i % 4 == 3) ? 32'd7 : 32'd2);
    end
    wait_acks(9, "t1r");
    chk("t1_restart", ack_adr_log[8], 32'h1000);
    go_idle();
    chk("t1_pop0", pop_log[0], 32'h1000);
    chk("t1_pop7", pop_log[7], 32'h101C);
    chk("t1_no_loss", pops_total, acks_total);

    // Partial final burst
    clear_logs();
    configure(32'h1000, 6, 4);
    enable = 1'b1;
    wait_acks(6, "t2");
    chk("t2_adr4", ack_adr_log[4], 32'h1010);
    chk("t2_cti4", 32'(ack_cti_log[4]), 2);
    chk("t2_adr5", ack_adr_log[5], 32'h1014);
    chk("t2_cti5", 32'(ack_cti_log[5]), 7);
    chk("t2_wrap", wrap_o, 1);
    go_idle();

    // Backpressure
    clear_logs();
    configure(32'h1000, 64, 4);
    stream_m_ready_i = 1'b0;
    enable = 1'b1;
    repeat (80) step();
    chk("bp_fetched", acks_total, 16);
    chk("bp_cyc", wbm_cyc_o, 0);
    chk("bp_valid", stream_m_valid_o, 1);
    chk("bp_data", stream_m_data_o, 32'h1000);
    stream_m_ready_i = 1'b1;
    repeat (4) step();
    stream_m_ready_i = 1'b0;
    k = 0;
    while (!wbm_cyc_o && k < 2) begin step(); k++; end
    chk("bp_restart", wbm_cyc_o, 1);
    stream_m_ready_i = 1'b1;
    repeat (60) step();
    go_idle();
    chk("bp_no_loss", pops_total, acks_total);

    // Error on beat 3
    clear_logs();
    configure(32'h1000, 16, 4);
    inj_err_beat = 3;
    enable = 1'b1;
    k = 0;
    while (!err_o && k < 100) begin step(); k++; end
    chk("err_flag", err_o, 1);
    chk("err_cyc", wbm_cyc_o, 0);
    chk("err_acks", acks_total, 2);
    repeat (4) step();
    chk("err_pops", pops_total, 2);
    chk("err_pop1", pop_log[1], 32'h1004);
    enable = 1'b0;
    step(); step();
    chk("err_exit_busy", busy_o, 0);
    chk("err_exit_err", err_o, 0);
    clear_logs();
    enable = 1'b1;
    wait_acks(1, "err_rs");
    chk("err_restart", ack_adr_log[0], 32'h1000);
    go_idle();

    // Enable drop mid-burst
    clear_logs();
    configure(32'h2000, 16, 4);
    enable = 1'b1;
    wait_acks(1, "ed");
    enable = 1'b0;
    k = 0;
    while (busy_o && k < 100) begin step(); k++; end
    chk("ed_beats", acks_total, 4);
    chk("ed_busy", busy_o, 0);
    go_idle();

    // Reset mid-burst
    clear_logs();
    configure(32'h3000, 16, 4);
    enable = 1'b1;
    wait_acks(1, "rm");
    rst_n = 1'b0;
    step();
    chk("rm_cyc", wbm_cyc_o, 0);
    chk("rm_valid", stream_m_valid_o, 0);
    chk("rm_busy", busy_o, 0);
    rst_n = 1'b1;
    enable = 1'b0;
    go_idle();

    // burst_size 0 -> single beats
    clear_logs();
    configure(32'h4000, 3, 0);
    enable = 1'b1;
    wait_acks(3, "b0");
    for (int i = 0; i < 3; i++) chk("b0_cti", 32'(ack_cti_log[i]), 7);
    go_idle();

    // burst_size 100 -> bursts of 16
    clear_logs();
    configure(32'h5000, 40, 100);
    enable = 1'b1;
    wait_acks(16, "b100");
    chk("b100_cti14", 32'(ack_cti_log[14]), 2);
    chk("b100_cti15", 32'(ack_cti_log[15]), 7);
    go_idle();

    // buf_size 0 -> nothing happens
    clear_logs();
    configure(32'h6000, 0, 4);
    enable = 1'b1;
    repeat (20) step();
    chk("b0buf_busy", busy_o, 0);
    chk("b0buf_cyc_seen", cyc_seen, 0);
    go_idle();

    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      logic [31:0] sa;
      int run;
      sa = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      configure(sa, $urandom_range(1, 40), $urandom_range(0, 20));
      ack_pct = $urandom_range(30, 100);
      rty_pct = 50;
      if ($urandom_range(0, 4) == 0) inj_err_beat = $urandom_range(1, 3);
      rand_ready = 1;
      enable = 1'b1;
      run = $urandom_range(50, 300);
      for (int c = 0; c < run; c++) begin
        if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      go_idle();
    end
    ack_pct = 100;
    rty_pct = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
